// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//
// Purpose:
//   Initiator side of the ALU operand/result interface. It accepts one ALU
//   operation per request handshake, drives control/operands into the ALU from
//   registers, waits a fixed ALU latency, captures result/overflow/zero and
//   returns them with the request tag on a response handshake.
//
// Parameters:
//   ALU_LAT  cycles from the operand-register update edge to valid ALU outputs
//            (0 = combinational ALU), legal range 0..7
//   TAG_W    width of the request/response tag
//
// Ports:
//   clk, rst_n                        clock (rising edge), async active-low reset
//   i_req_valid / o_req_ready         request handshake
//   i_req_ctrl, i_req_a, i_req_b      ALU control code and operands
//   i_req_tag                         tag carried through to the response
//   o_alu_ctrl, o_alu_oper1/2         registered drive into the ALU
//   i_alu_result/overflow/zero        ALU outputs
//   o_rsp_valid / i_rsp_ready         response handshake
//   o_rsp_result/overflow/zero/tag    captured response payload
//   o_busy                            high while an operation is in flight
//   o_ovf_count                       saturating count of captured overflows
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned TAG_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    // request side
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [3:0]       i_req_ctrl,
    input  logic [31:0]      i_req_a,
    input  logic [31:0]      i_req_b,
    input  logic [TAG_W-1:0] i_req_tag,
    // ALU side
    output logic [3:0]       o_alu_ctrl,
    output logic [31:0]      o_alu_oper1,
    output logic [31:0]      o_alu_oper2,
    input  logic [31:0]      i_alu_result,
    input  logic             i_alu_overflow,
    input  logic             i_alu_zero,
    // response side
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [31:0]      o_rsp_result,
    output logic             o_rsp_overflow,
    output logic             o_rsp_zero,
    output logic [TAG_W-1:0] o_rsp_tag,
    // status
    output logic             o_busy,
    output logic [7:0]       o_ovf_count
);

    localparam int unsigned      CNT_W    = 3;
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(ALU_LAT);
    localparam logic [7:0]       OVF_MAX  = 8'hFF;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;

    logic [3:0]        r_alu_ctrl;
    logic [31:0]       r_alu_oper1;
    logic [31:0]       r_alu_oper2;
    logic [TAG_W-1:0]  r_tag;

    logic              r_rsp_valid;
    logic [31:0]       r_rsp_result;
    logic              r_rsp_overflow;
    logic              r_rsp_zero;
    logic [TAG_W-1:0]  r_rsp_tag;
    logic [7:0]        r_ovf_count;

    logic              w_req_ready;
    logic              w_accept;
    logic              w_capture;
    logic              w_retire;

    // Ready in RESP depends only on rsp_ready so a retiring response frees the
    // slot for a back-to-back request in the same cycle.
    assign w_req_ready = (r_state == StIdle) || ((r_state == StResp) && i_rsp_ready);
    assign w_accept    = i_req_valid && w_req_ready;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_retire    = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (i_req_valid) begin
                    w_state_nxt = StWait;
                end
            end
            StWait: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_capture   = 1'b1;
                    w_state_nxt = StResp;
                end
            end
            StResp: begin
                if (i_rsp_ready) begin
                    w_retire    = 1'b1;
                    w_state_nxt = i_req_valid ? StWait : StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase

        // Latency countdown restarts on every accepted request.
        if (w_accept) begin
            w_cnt_nxt = LAT_INIT;
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Operand registers: only an accept may change them, so the ALU inputs are
    // stable for the whole computation and response phase.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_ctrl  <= 4'd0;
            r_alu_oper1 <= 32'd0;
            r_alu_oper2 <= 32'd0;
            r_tag       <= '0;
        end else if (w_accept) begin
            r_alu_ctrl  <= i_req_ctrl;
            r_alu_oper1 <= i_req_a;
            r_alu_oper2 <= i_req_b;
            r_tag       <= i_req_tag;
        end
    end

    // -------------------------------------------------------------------------
    // Response registers: payload only changes at capture, so it holds under
    // backpressure.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid    <= 1'b0;
            r_rsp_result   <= 32'd0;
            r_rsp_overflow <= 1'b0;
            r_rsp_zero     <= 1'b0;
            r_rsp_tag      <= '0;
        end else if (w_capture) begin
            r_rsp_valid    <= 1'b1;
            r_rsp_result   <= i_alu_result;
            r_rsp_overflow <= i_alu_overflow;
            r_rsp_zero     <= i_alu_zero;
            r_rsp_tag      <= r_tag;
        end else if (w_retire) begin
            r_rsp_valid    <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Overflow statistics, saturating at 255.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_count <= 8'd0;
        end else if (w_capture && i_alu_overflow && (r_ovf_count != OVF_MAX)) begin
            r_ovf_count <= r_ovf_count + 8'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_req_ready    = w_req_ready;
    assign o_alu_ctrl     = r_alu_ctrl;
    assign o_alu_oper1    = r_alu_oper1;
    assign o_alu_oper2    = r_alu_oper2;
    assign o_rsp_valid    = r_rsp_valid;
    assign o_rsp_result   = r_rsp_result;
    assign o_rsp_overflow = r_rsp_overflow;
    assign o_rsp_zero     = r_rsp_zero;
    assign o_rsp_tag      = r_rsp_tag;
    assign o_busy         = (r_state != StIdle);
    assign o_ovf_count    = r_ovf_count;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_ctrl
//
// Bench for alu_issue_ctrl. One instance uses ALU_LAT=1 with a registered ALU
// model, a second uses ALU_LAT=0 with a combinational ALU model. Expected
// responses for the main instance are pushed to a queue at request accept and
// compared when the response handshake completes.
// -----------------------------------------------------------------------------
module tb_alu_issue_ctrl;

    localparam int unsigned TAG_W = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- ALU_LAT = 1 instance ----------------
    logic             req_valid, req_ready;
    logic [3:0]       req_ctrl;
    logic [31:0]      req_a, req_b;
    logic [TAG_W-1:0] req_tag;
    logic [3:0]       alu_ctrl;
    logic [31:0]      alu_oper1, alu_oper2, alu_result;
    logic             alu_overflow, alu_zero;
    logic             rsp_valid, rsp_ready;
    logic [31:0]      rsp_result;
    logic             rsp_overflow, rsp_zero;
    logic [TAG_W-1:0] rsp_tag;
    logic             busy;
    logic [7:0]       ovf_count;

    // ---------------- ALU_LAT = 0 instance ----------------
    logic             req_valid0, req_ready0;
    logic [3:0]       req_ctrl0;
    logic [31:0]      req_a0, req_b0;
    logic [TAG_W-1:0] req_tag0;
    logic [3:0]       alu_ctrl0;
    logic [31:0]      alu_oper1_0, alu_oper2_0, alu_result0;
    logic             alu_overflow0, alu_zero0;
    logic             rsp_valid0, rsp_ready0;
    logic [31:0]      rsp_result0;
    logic             rsp_overflow0, rsp_zero0;
    logic [TAG_W-1:0] rsp_tag0;
    logic             busy0;
    logic [7:0]       ovf_count0;

    // ALU reference: ctrl 1 = subtract, anything else = add. {ovf, zero, result}
    function automatic logic [33:0] alu_fn(input logic [3:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] s;
        logic        v;
        if (c == 4'd1) begin
            s = a - b;
            v = (a[31] != b[31]) && (s[31] != a[31]);
        end else begin
            s = a + b;
            v = (a[31] == b[31]) && (s[31] != a[31]);
        end
        return {v, (s == 32'd0), s};
    endfunction

    logic [33:0] alu1_q;
    always @(posedge clk) alu1_q <= alu_fn(alu_ctrl, alu_oper1, alu_oper2);
    assign {alu_overflow, alu_zero, alu_result} = alu1_q;

    logic [33:0] alu0_w;
    assign alu0_w = alu_fn(alu_ctrl0, alu_oper1_0, alu_oper2_0);
    assign {alu_overflow0, alu_zero0, alu_result0} = alu0_w;

    alu_issue_ctrl #(.ALU_LAT(1), .TAG_W(TAG_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_ctrl     (req_ctrl),
        .i_req_a        (req_a),
        .i_req_b        (req_b),
        .i_req_tag      (req_tag),
        .o_alu_ctrl     (alu_ctrl),
        .o_alu_oper1    (alu_oper1),
        .o_alu_oper2    (alu_oper2),
        .i_alu_result   (alu_result),
        .i_alu_overflow (alu_overflow),
        .i_alu_zero     (alu_zero),
        .o_rsp_valid    (rsp_valid),
        .i_rsp_ready    (rsp_ready),
        .o_rsp_result   (rsp_result),
        .o_rsp_overflow (rsp_overflow),
        .o_rsp_zero     (rsp_zero),
        .o_rsp_tag      (rsp_tag),
        .o_busy         (busy),
        .o_ovf_count    (ovf_count)
    );

    alu_issue_ctrl #(.ALU_LAT(0), .TAG_W(TAG_W)) dut0 (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_req_valid    (req_valid0),
        .o_req_ready    (req_ready0),
        .i_req_ctrl     (req_ctrl0),
        .i_req_a        (req_a0),
        .i_req_b        (req_b0),
        .i_req_tag      (req_tag0),
        .o_alu_ctrl     (alu_ctrl0),
        .o_alu_oper1    (alu_oper1_0),
        .o_alu_oper2    (alu_oper2_0),
        .i_alu_result   (alu_result0),
        .i_alu_overflow (alu_overflow0),
        .i_alu_zero     (alu_zero0),
        .o_rsp_valid    (rsp_valid0),
        .i_rsp_ready    (rsp_ready0),
        .o_rsp_result   (rsp_result0),
        .o_rsp_overflow (rsp_overflow0),
        .o_rsp_zero     (rsp_zero0),
        .o_rsp_tag      (rsp_tag0),
        .o_busy         (busy0),
        .o_ovf_count    (ovf_count0)
    );

    typedef struct packed {
        logic [31:0]      res;
        logic             ovf;
        logic             zero;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    logic accepted = 1'b0;
    logic prev_valid = 1'b0;
    int   exp_ovf;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // One cycle: monitor the main instance at the falling edge, then advance to
    // just after the next rising edge where stimulus is driven.
    task automatic tick();
        exp_t        e;
        logic [33:0] r;
        int          a;
        @(negedge clk);
        accepted = 1'b0;
        if (req_valid && req_ready) begin
            r = alu_fn(req_ctrl, req_a, req_b);
            e.res  = r[31:0];
            e.zero = r[32];
            e.ovf  = r[33];
            e.tag  = req_tag;
            exp_q.push_back(e);
            acc_q.push_back(cyc);
            accepted = 1'b1;
        end
        if (rsp_valid && !prev_valid) begin
            chk("rsp_pending", 32'(acc_q.size() != 0), 32'd1);
            if (acc_q.size() != 0) begin
                a = acc_q.pop_front();
                chk("rsp_latency", 32'(cyc), 32'(a + 3));
            end
        end
        if (rsp_valid && rsp_ready) begin
            chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rsp_result", rsp_result, e.res);
                chk("rsp_overflow", 32'(rsp_overflow), 32'(e.ovf));
                chk("rsp_zero", 32'(rsp_zero), 32'(e.zero));
                chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
            end
        end
        prev_valid = rsp_valid;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] t);
        req_ctrl  = c;
        req_a     = a;
        req_b     = b;
        req_tag   = t;
        req_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (accepted) break;
        end
        chk("req_accepted", 32'(accepted), 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0; req_ctrl  = 4'd0; req_a  = 32'd0; req_b  = 32'd0; req_tag  = '0;
        rsp_ready  = 1'b1;
        req_valid0 = 1'b0; req_ctrl0 = 4'd0; req_a0 = 32'd0; req_b0 = 32'd0; req_tag0 = '0;
        rsp_ready0 = 1'b1;

        // Reset state
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_oper1", alu_oper1, 32'd0);
        chk("rst_oper2", alu_oper2, 32'd0);
        chk("rst_ctrl", 32'(alu_ctrl), 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
        chk("rst_ovf_count", 32'(ovf_count), 32'd0);
        chk("rst0_busy", 32'(busy0), 32'd0);
        chk("rst0_ovf_count", 32'(ovf_count0), 32'd0);

        // 7 + 3, tag 5
        send(4'd0, 32'd7, 32'd3, 5'd5);
        chk("add_oper1", alu_oper1, 32'd7);
        chk("add_oper2", alu_oper2, 32'd3);
        chk("add_busy", 32'(busy), 32'd1);
        chk("add_wait_not_ready", 32'(req_ready), 32'd0);
        drain();
        chk("add_idle", 32'(busy), 32'd0);
        chk("add_idle_ready", 32'(req_ready), 32'd1);

        // Zero flag, overflow flag, subtract pass-through
        send(4'd0, 32'd0, 32'd0, 5'd1);
        drain();
        send(4'd0, 32'h7FFF_FFFF, 32'd1, 5'd2);
        drain();
        chk("ovf_count_1", 32'(ovf_count), 32'd1);
        send(4'd1, 32'd5, 32'd7, 5'd9);
        chk("sub_ctrl", 32'(alu_ctrl), 32'd1);
        drain();

        // Backpressure with a pending request, then back-to-back accept
        rsp_ready = 1'b0;
        send(4'd0, 32'd2, 32'd3, 5'd3);
        req_ctrl = 4'd0; req_a = 32'd3; req_b = 32'd3; req_tag = 5'd4; req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) break;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_hold", rsp_result, 32'd5);
            chk("bp_oper1_hold", alu_oper1, 32'd2);
            chk("bp_oper2_hold", alu_oper2, 32'd3);
            chk("bp_not_ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("b2b_ready", 32'(req_ready), 32'd1);
        tick();
        chk("b2b_accepted", 32'(accepted), 32'd1);
        req_valid = 1'b0;
        chk("b2b_oper1", alu_oper1, 32'd3);
        chk("b2b_rsp_dropped", 32'(rsp_valid), 32'd0);
        drain();

        // Reset during WAIT discards the operation
        send(4'd0, 32'd1, 32'd1, 5'd7);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_oper1", alu_oper1, 32'd0);
        chk("mid_rst_oper2", alu_oper2, 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_ovf_count", 32'(ovf_count), 32'd0);
        exp_q.delete();
        acc_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        send(4'd0, 32'd1, 32'd1, 5'd7);
        drain();

        // Overflow counter saturation
        exp_ovf = 0;
        for (int i = 0; i < 256; i++) begin
            send(4'd0, 32'h7FFF_FFFF, 32'd1, 5'(i));
            drain();
            if (exp_ovf < 255) exp_ovf++;
            chk("ovf_count_sat", 32'(ovf_count), 32'(exp_ovf));
        end
        send(4'd0, 32'd4, 32'd4, 5'd0);
        drain();
        chk("ovf_count_hold", 32'(ovf_count), 32'd255);

        // ALU_LAT = 0 instance: response in cycle 2 after the request cycle
        req_ctrl0 = 4'd0; req_a0 = 32'd7; req_b0 = 32'd3; req_tag0 = 5'd5; req_valid0 = 1'b1;
        chk("l0_ready", 32'(req_ready0), 32'd1);
        tick();
        req_valid0 = 1'b0;
        chk("l0_c1_rsp_valid", 32'(rsp_valid0), 32'd0);
        chk("l0_c1_oper1", alu_oper1_0, 32'd7);
        chk("l0_c1_oper2", alu_oper2_0, 32'd3);
        chk("l0_c1_busy", 32'(busy0), 32'd1);
        tick();
        chk("l0_c2_rsp_valid", 32'(rsp_valid0), 32'd1);
        chk("l0_c2_result", rsp_result0, 32'd10);
        chk("l0_c2_zero", 32'(rsp_zero0), 32'd0);
        chk("l0_c2_overflow", 32'(rsp_overflow0), 32'd0);
        chk("l0_c2_tag", 32'(rsp_tag0), 32'd5);
        tick();
        chk("l0_c3_rsp_valid", 32'(rsp_valid0), 32'd0);
        chk("l0_c3_busy", 32'(busy0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
